serial_word_collector: RTL and testbench

//  Downstream stage of the 18-bit shift register: consumes its serial Shift_Out stream, one bit per Shift_En.

---
 rtl/serial_word_collector.sv | 172 +++++++++++++++++
 tb/tb_serial_word_collector.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_collector.sv
// serial_word_collector
//   Rebuilds LSB-first words from a serial bit stream (one bit per Bit_Valid)
//   and buffers them in a DEPTH-entry first-word-fall-through FIFO drained by
//   a valid/ready handshake. A completed word that finds the FIFO full (with
//   no simultaneous pop) is dropped and raises the sticky Overflow flag.
//
//   Optional feature macro: SERIAL_WORD_COLLECTOR_PARITY_EN
//     When defined, each frame carries one trailing even-parity bit. A frame
//     whose data+parity XOR is 1 is dropped and Parity_Err pulses for a cycle.
//     When undefined, Parity_Err is tied low.
//
// Ports
//   Clk          system clock, rising edge
//   Reset        asynchronous active-low reset
//   Bit_In       serial data
//   Bit_Valid    Bit_In is accepted this edge
//   Frame_Start  realign: the current/next accepted bit becomes bit 0
//   Out_Ready    consumer takes Out_Data this edge
//   Clear_Ovf    clears Overflow (a same-edge set wins)
//   Out_Data     head-of-FIFO word, 0 when empty
//   Out_Valid    FIFO non-empty
//   Count        words stored
//   Overflow     sticky, a completed word was dropped
//   Parity_Err   one-cycle pulse on a parity failure (macro build only)

module serial_word_collector #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Bit_In,
  input  logic                         Bit_Valid,
  input  logic                         Frame_Start,
  input  logic                         Out_Ready,
  input  logic                         Clear_Ovf,
  output logic [WIDTH-1:0]             Out_Data,
  output logic                         Out_Valid,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Overflow,
  output logic                         Parity_Err
);

`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW   = $clog2(FRAME_LEN);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             parity_err_q, parity_err_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             frame_end;
  logic             last_bit;
  logic             data_bit;
  logic [WIDTH-1:0] word_shift;
  logic [WIDTH-1:0] push_word;
  logic             push_req;
  logic             par_fail;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             ovf_set;

  assign frame_end  = (bit_cnt_q == CW'(FRAME_LEN - 1));
  // Frame_Start overrides completion, so a realigning edge never pushes.
  assign last_bit   = Bit_Valid && !Frame_Start && frame_end;
  assign word_shift = {Bit_In, asm_q[WIDTH-1:1]};

`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
  logic parity_bad;
  // Only data bits shift into the assembly register; the parity bit is checked, not stored.
  assign data_bit   = (bit_cnt_q < CW'(WIDTH));
  assign parity_bad = (^asm_q) ^ Bit_In;
  assign push_req   = last_bit && !parity_bad;
  assign par_fail   = last_bit && parity_bad;
  assign push_word  = asm_q;
`else
  // asm_q[0] shifts out on the completing edge and is never part of a pushed word.
  logic unused_asm_lsb;
  assign unused_asm_lsb = asm_q[0];
  assign data_bit   = 1'b1;
  assign push_req   = last_bit;
  assign par_fail   = 1'b0;
  assign push_word  = word_shift;
`endif

  // Word assembly
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    asm_d     = asm_q;
    if (Frame_Start) begin
      if (Bit_Valid) begin
        bit_cnt_d = CW'(1);
        asm_d     = {Bit_In, {(WIDTH-1){1'b0}}};
      end else begin
        bit_cnt_d = '0;
        asm_d     = '0;
      end
    end else if (Bit_Valid) begin
      bit_cnt_d = frame_end ? '0 : bit_cnt_q + CW'(1);
      if (data_bit) begin
        asm_d = word_shift;
      end
    end
  end

  // FIFO control
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNTW'(DEPTH));
  assign pop     = !empty && Out_Ready;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push_ok = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;

  always_comb begin
    wr_ptr_d     = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d      = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
    overflow_d   = ovf_set ? 1'b1 : (Clear_Ovf ? 1'b0 : overflow_q);
    parity_err_d = par_fail;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bit_cnt_q    <= '0;
      asm_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      asm_q        <= asm_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      parity_err_q <= parity_err_d;
    end
  end

  // Storage needs no reset: Out_Data is masked while the FIFO is empty.
  always_ff @(posedge Clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  assign Out_Valid  = !empty;
  assign Out_Data   = empty ? '0 : mem_q[rd_ptr_q];
  assign Count      = count_q;
  assign Overflow   = overflow_q;
  assign Parity_Err = parity_err_q;

endmodule

// File: tb/tb_serial_word_collector.sv
module tb_serial_word_collector;
  localparam int W = 18;
  localparam int D = 4;
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = W + int'(PAR);

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         Bit_In = 1'b0, Bit_Valid = 1'b0, Frame_Start = 1'b0;
  logic         Out_Ready = 1'b0, Clear_Ovf = 1'b0;
  logic [W-1:0] Out_Data;
  logic         Out_Valid;
  logic [2:0]   Count;
  logic         Overflow;
  logic         Parity_Err;

  serial_word_collector #(.WIDTH(W), .DEPTH(D)) dut (
    .Clk(Clk), .Reset(Reset), .Bit_In(Bit_In), .Bit_Valid(Bit_Valid),
    .Frame_Start(Frame_Start), .Out_Ready(Out_Ready), .Clear_Ovf(Clear_Ovf),
    .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Count(Count),
    .Overflow(Overflow), .Parity_Err(Parity_Err)
  );

  always #5 Clk = ~Clk;

  int tests_run = 0;
  int fails = 0;

  // Reference model: bits collected by position, words held in a queue.
  int            m_nbits;
  logic [FL-1:0] m_bits;
  logic [W-1:0]  m_q[$];
  bit            m_ovf;
  bit            m_perr;

  task automatic model_reset();
    m_nbits = 0;
    m_bits  = '0;
    m_q.delete();
    m_ovf   = 1'b0;
    m_perr  = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model over that edge, sample #1 after it.
  task automatic step(input logic bv, input logic b, input logic fs, input logic rdy, input logic clr);
    bit push, pop, full;
    logic [W-1:0] word;
    Bit_Valid = bv; Bit_In = b; Frame_Start = fs; Out_Ready = rdy; Clear_Ovf = clr;
    push = 1'b0; m_perr = 1'b0; word = '0;
    if (fs) begin
      m_bits = '0;
      if (bv) begin m_bits[0] = b; m_nbits = 1; end
      else m_nbits = 0;
    end else if (bv) begin
      m_bits[m_nbits] = b;
      m_nbits++;
      if (m_nbits == FL) begin
        word = m_bits[W-1:0];
        if (PAR && (^m_bits)) m_perr = 1'b1;
        else push = 1'b1;
        m_bits = '0;
        m_nbits = 0;
      end
    end
    full = (m_q.size() == D);
    pop  = (m_q.size() > 0) && rdy;
    if (pop) void'(m_q.pop_front());
    if (push && !(full && !pop)) m_q.push_back(word);
    if (push && full && !pop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    Bit_Valid = 0; Bit_In = 0; Frame_Start = 0; Out_Ready = 0; Clear_Ovf = 0;
    model_reset();
    @(posedge Clk); #3;
    Reset = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy_last);
    for (int i = 0; i < FL; i++)
      step(1'b1, (i < W) ? w[i] : ^w, 1'b0, (i == FL-1) ? rdy_last : 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    tests_run++; if (Out_Valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", Out_Valid); end
    tests_run++; if (Out_Data !== '0) begin fails++; $display("FAIL reset_data: got %h expected 0", Out_Data); end
    tests_run++; if (Count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", Count); end
    tests_run++; if (Overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b expected 0", Overflow); end
    tests_run++; if (Parity_Err !== 1'b0) begin fails++; $display("FAIL reset_perr: got %b expected 0", Parity_Err); end
    @(negedge Clk); Reset = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_single_word();
    logic [W-1:0] w;
    w = 18'h2A5C3;
    do_reset();
    for (int i = 0; i < FL-1; i++) step(1'b1, (i < W) ? w[i] : ^w, 1'b0, 1'b0, 1'b0);
    tests_run++; if (Out_Valid !== 1'b0) begin fails++; $display("FAIL single_early_valid: got %b expected 0", Out_Valid); end
    step(1'b1, (FL-1 < W) ? w[FL-1] : ^w, 1'b0, 1'b0, 1'b0);
    tests_run++; if (Out_Valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", Out_Valid); end
    tests_run++; if (Out_Data !== 18'h2A5C3) begin fails++; $display("FAIL single_data: got %h expected 2a5c3", Out_Data); end
    tests_run++; if (Count !== 3'd1) begin fails++; $display("FAIL single_count: got %0d expected 1", Count); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tests_run++; if (Count !== 3'd0 || Out_Valid !== 1'b0) begin fails++; $display("FAIL single_pop: got count %0d valid %b expected 0 0", Count, Out_Valid); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] w[5];
    do_reset();
    for (int k = 0; k < 5; k++) begin w[k] = W'($urandom); send_word(w[k], 1'b0); end
    tests_run++; if (Count !== 3'd4) begin fails++; $display("FAIL ovf_count: got %0d expected 4", Count); end
    tests_run++; if (Overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b expected 1", Overflow); end
    for (int k = 0; k < 4; k++) begin
      tests_run++; if (Out_Data !== w[k]) begin fails++; $display("FAIL ovf_order%0d: got %h expected %h", k, Out_Data, w[k]); end
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    tests_run++; if (Out_Valid !== 1'b0) begin fails++; $display("FAIL ovf_lost: got valid %b expected 0", Out_Valid); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tests_run++; if (Overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b expected 0", Overflow); end
  endtask

  task automatic test_full_pop();
    logic [W-1:0] w[5];
    do_reset();
    for (int k = 0; k < 4; k++) begin w[k] = W'($urandom); send_word(w[k], 1'b0); end
    w[4] = W'($urandom);
    send_word(w[4], 1'b1);
    tests_run++; if (Count !== 3'd4) begin fails++; $display("FAIL fullpop_count: got %0d expected 4", Count); end
    tests_run++; if (Overflow !== 1'b0) begin fails++; $display("FAIL fullpop_ovf: got %b expected 0", Overflow); end
    for (int k = 1; k < 5; k++) begin
      tests_run++; if (Out_Data !== w[k]) begin fails++; $display("FAIL fullpop_order%0d: got %h expected %h", k, Out_Data, w[k]); end
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_frame_start();
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 17; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++; if (Count !== 3'd0) begin fails++; $display("FAIL fs_no_early_push: got %0d expected 0", Count); end
    for (int i = 17; i < FL; i++) step(1'b1, (i < W) ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++; if (Count !== 3'd1) begin fails++; $display("FAIL fs_count: got %0d expected 1", Count); end
    tests_run++; if (Out_Data !== 18'h00001) begin fails++; $display("FAIL fs_data: got %h expected 00001", Out_Data); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tests_run++; if (Count !== 3'd0) begin fails++; $display("FAIL fs_single: got %0d expected 0", Count); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w;
    do_reset();
    send_word(W'($urandom), 1'b0);
    send_word(W'($urandom), 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
    tests_run++; if (Count !== 3'd2) begin fails++; $display("FAIL rstmid_pre: got %0d expected 2", Count); end
    #2; Reset = 1'b0; Bit_Valid = 1'b0; #1;
    model_reset();
    tests_run++; if (Out_Valid !== 1'b0 || Count !== 3'd0 || Out_Data !== '0 || Overflow !== 1'b0)
      begin fails++; $display("FAIL rstmid_async: got valid %b count %0d data %h ovf %b expected 0", Out_Valid, Count, Out_Data, Overflow); end
    @(negedge Clk); Reset = 1'b1;
    @(posedge Clk); #1;
    w = W'($urandom);
    for (int i = 0; i < FL-1; i++) step(1'b1, (i < W) ? w[i] : ^w, 1'b0, 1'b0, 1'b0);
    tests_run++; if (Count !== 3'd0) begin fails++; $display("FAIL rstmid_partial: got %0d expected 0", Count); end
    step(1'b1, (FL-1 < W) ? w[FL-1] : ^w, 1'b0, 1'b0, 1'b0);
    tests_run++; if (Count !== 3'd1 || Out_Data !== w) begin fails++; $display("FAIL rstmid_word: got count %0d data %h expected 1 %h", Count, Out_Data, w); end
  endtask

`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] w;
    do_reset();
    w = 18'h00003;
    for (int i = 0; i < FL; i++) step(1'b1, (i < W) ? w[i] : 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++; if (Count !== 3'd1 || Parity_Err !== 1'b0) begin fails++; $display("FAIL par_good: got count %0d perr %b expected 1 0", Count, Parity_Err); end
    w = 18'h00001;
    for (int i = 0; i < FL; i++) step(1'b1, (i < W) ? w[i] : 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++; if (Parity_Err !== 1'b1 || Count !== 3'd1) begin fails++; $display("FAIL par_bad: got perr %b count %0d expected 1 1", Parity_Err, Count); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++; if (Parity_Err !== 1'b0 || Overflow !== 1'b0) begin fails++; $display("FAIL par_pulse: got perr %b ovf %b expected 0 0", Parity_Err, Overflow); end
  endtask
`endif

  task automatic test_random();
    logic bv, b, fs, rdy, clr;
    logic [W-1:0] exp_data;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bv  = ($urandom_range(0, 3) != 0);
      b   = 1'($urandom);
      fs  = ($urandom_range(0, 63) == 0);
      rdy = (n < 1500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 15) == 0);
      step(bv, b, fs, rdy, clr);
      exp_data = (m_q.size() > 0) ? m_q[0] : '0;
      tests_run++; if (Count !== 3'(m_q.size())) begin fails++; $display("FAIL rnd_count@%0d: got %0d expected %0d", n, Count, m_q.size()); end
      tests_run++; if (Out_Valid !== (m_q.size() > 0)) begin fails++; $display("FAIL rnd_valid@%0d: got %b expected %b", n, Out_Valid, m_q.size() > 0); end
      tests_run++; if (Out_Data !== exp_data) begin fails++; $display("FAIL rnd_data@%0d: got %h expected %h", n, Out_Data, exp_data); end
      tests_run++; if (Overflow !== m_ovf) begin fails++; $display("FAIL rnd_ovf@%0d: got %b expected %b", n, Overflow, m_ovf); end
      tests_run++; if (Parity_Err !== m_perr) begin fails++; $display("FAIL rnd_perr@%0d: got %b expected %b", n, Parity_Err, m_perr); end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_overflow();
    test_full_pop();
    test_frame_start();
    test_reset_mid();
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
